// File: rtl/key_press_gen.sv
// Synthetic key-press generator: each accepted req becomes one HOLD_CYCLES-high press followed
// by at least GAP_CYCLES low. Define KEY_PRESS_GEN_QUEUE_EN to queue requests made while busy.
module key_press_gen #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned QUEUE_DEPTH = 3,
    localparam int unsigned PendW      = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             req,
    output logic             key,
    output logic             busy,
    output logic             done,
    output logic             dropped,
    output logic [PendW-1:0] pending
);

    localparam int unsigned MaxCycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPress, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            key_q, key_d;
    logic            done_q, done_d;
    logic            drop_q, drop_d;
    logic            last;

`ifdef KEY_PRESS_GEN_QUEUE_EN
    localparam logic [PendW-1:0] PendMax = PendW'(QUEUE_DEPTH);
    logic [PendW-1:0] pend_q, pend_d;
    logic             accept;
    logic             consume;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        last    = (cnt_q == '0);
`ifdef KEY_PRESS_GEN_QUEUE_EN
        pend_d  = pend_q;
        accept  = 1'b0;
        consume = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StPress;
                    cnt_d   = HoldLoad;
                end
            end
            StPress: begin
                if (last) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGap: begin
                if (last) begin
`ifdef KEY_PRESS_GEN_QUEUE_EN
                    if (pend_q != '0 || req) begin
                        state_d = StPress;
                        cnt_d   = HoldLoad;
                        consume = (pend_q != '0);
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

`ifdef KEY_PRESS_GEN_QUEUE_EN
        // With an empty queue, a req on the last gap cycle starts the next press directly.
        if (req && state_q != StIdle &&
            !(state_q == StGap && last && pend_q == '0)) begin
            if (pend_q < PendMax) begin
                accept = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end

        case ({accept, consume})
            2'b10:   pend_d = pend_q + PendW'(1);
            2'b01:   pend_d = pend_q - PendW'(1);
            default: pend_d = pend_q;
        endcase
`else
        drop_d = req && (state_q != StIdle);
`endif

        key_d  = (state_d == StPress);
        done_d = (state_q == StPress) && (state_d == StGap);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

`ifdef KEY_PRESS_GEN_QUEUE_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;
`else
    assign pending = '0;
`endif

    assign key     = key_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign dropped = drop_q;

endmodule

// File: doc/key_press_gen.md
# key_press_gen

Synthetic key-press generator: the transmit-side counterpart of the key-release detectors. Each accepted one-cycle `req` pulse becomes one clean press-and-release waveform on `key`. The press is high for exactly `HOLD_CYCLES` and is followed by a low gap of at least `GAP_CYCLES`. The block drives the computer-player side of the game logic and stimulates release detectors in benches. Optional queueing absorbs requests that arrive while a press is in progress.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles `key` is held high per press (≥1).
- `GAP_CYCLES`, default 2: minimum low cycles after each release (≥1).
- `QUEUE_DEPTH`, default 3: maximum pending requests (≥1).

Ports:
- `Clock`  in  1: single clock, rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  1: press request, sampled on the rising edge of `Clock`.
- `key`  out  1: generated key line.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse marking each release.
- `dropped`  out  1: one-cycle pulse when a request is discarded.
- `pending`  out  $clog2(QUEUE_DEPTH+1): number of queued requests.

## Operation
- States:
  - IDLE: `key`=0.
  - PRESS: `key`=1; down-counter loaded with HOLD_CYCLES-1.
  - GAP: `key`=0; counter loaded with GAP_CYCLES-1.
- IDLE → PRESS when `req`=1. In IDLE a request is never queued and never dropped.
- PRESS → GAP when the counter reaches 0.
- GAP, last cycle (counter at 0):
  - → PRESS if `pending`>0 or `req`=1 that cycle.
  - Otherwise → IDLE.
- Queue (macro enabled):
  - `req`=1 in PRESS or GAP increments `pending` if `pending`<QUEUE_DEPTH.
  - Otherwise `dropped` pulses and `pending` is unchanged.
  - Entering PRESS from GAP consumes one request.
  - Simultaneous accept and consume on the last GAP cycle leaves `pending` unchanged. With `pending`=0, that `req` starts the press directly.
- `done`=1 only in the first GAP cycle, i.e. the first cycle `key` is low after a press.
- Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)). No wrap: counters reload on every state entry.
- `key`, `done` and `dropped` are registered. `busy` is decoded from the state register.

## Timing
- Reset (asynchronous, immediate): `key`=0, `busy`=0, `done`=0, `dropped`=0, `pending`=0, state=IDLE.
- Reset asserted mid-press forces `key` low without a `done` pulse and clears the queue. Operation resumes on the first edge after release.
- Latency: `req` sampled at edge E in IDLE gives `key`=1 from E through E+HOLD_CYCLES. `done`=1 for the cycle after E+HOLD_CYCLES.
  - `busy` is low after E+HOLD_CYCLES+GAP_CYCLES when no further requests are pending.
- Back-to-back presses are separated by exactly GAP_CYCLES low cycles.
- Press period is HOLD_CYCLES+GAP_CYCLES cycles.
- `done` and `dropped` are never high for more than one consecutive cycle per event.

## Configuration
- Macro `KEY_PRESS_GEN_QUEUE_EN`.
- Defined: queue operates as described in Operation.
- Undefined:
  - `pending` is tied to 0 and the queue logic is removed.
  - Any `req` while `busy`=1 pulses `dropped` and is discarded. This includes the last GAP cycle.
  - GAP always returns to IDLE.

## Test plan
Defaults for all scenarios: HOLD_CYCLES=4, GAP_CYCLES=2, QUEUE_DEPTH=3.
1. Hold `Reset_n`=0 for 2 cycles with `req` toggling → `key`, `busy`, `done`, `dropped` all 0 and `pending`=0 throughout.
2. Single `req` at edge E → `key`=1 for 4 cycles; `done`=1 for one cycle after E+4; `busy`=0 after E+6.
3. Queue enabled, `req` at E, E+1, E+2 → `pending` reaches 2. Three 4-cycle presses, each pair separated by exactly 2 low cycles. Exactly 3 `done` pulses.
4. Queue enabled, 5 consecutive `req` cycles during the first press → `pending`=3. `dropped` pulses twice. Four total presses follow.
5. `Reset_n` low during the 2nd hold cycle → `key` falls without waiting for an edge. No `done`, `pending`=0. A fresh `req` afterward produces a normal 4-cycle press.
6. Macro undefined, `req` during PRESS and on the last GAP cycle → `dropped` pulses for each. `pending` stays 0. Exactly one press occurs.
